// File: rtl/poly_eval_pkg.sv
// rtl/poly_eval_pkg.sv - shared constants and state encoding for the polynomial evaluator
package poly_eval_pkg;

    localparam int XW_DEF  = 16;
    localparam int CW_DEF  = 16;
    localparam int YW_DEF  = 32;
    localparam int DEG_DEF = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MAC  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/poly_mac.sv
// rtl/poly_mac.sv - combinational acc*x + c step with wrap or clamp (POLY_SAT_EN)
module poly_mac
    import poly_eval_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int CW = CW_DEF,
    parameter int YW = YW_DEF
) (
    input  logic signed [YW-1:0] i_acc,
    input  logic signed [XW-1:0] i_x,
    input  logic signed [CW-1:0] i_c,
    output logic signed [YW-1:0] o_y,
    output logic                 o_sat
);

    localparam int PW = XW + YW;
    localparam int SW = PW + 1;

    logic signed [PW-1:0] w_prod;
    logic signed [SW-1:0] w_sum;

    assign w_prod = PW'(i_acc) * PW'(i_x);
    assign w_sum  = SW'(w_prod) + SW'(i_c);

`ifdef POLY_SAT_EN
    // In range only when every bit above the YW sign bit matches it.
    logic [SW-YW:0] w_hi;
    logic           w_out_of_range;

    assign w_hi           = w_sum[SW-1:YW-1];
    assign w_out_of_range = !((&w_hi) || !(|w_hi));

    always_comb begin
        o_sat = w_out_of_range;
        o_y   = w_sum[YW-1:0];
        if (w_out_of_range) begin
            o_y = w_sum[SW-1] ? {1'b1, {(YW-1){1'b0}}} : {1'b0, {(YW-1){1'b1}}};
        end
    end
`else
    logic w_unused_hi;

    assign w_unused_hi = ^w_sum[SW-1:YW];
    assign o_y         = w_sum[YW-1:0];
    assign o_sat       = 1'b0;
`endif

endmodule

// File: rtl/poly_eval_sm.sv
// rtl/poly_eval_sm.sv - Horner polynomial evaluator FSM; POLY_SAT_EN selects clamping
module poly_eval_sm
    import poly_eval_pkg::*;
#(
    parameter  int XW  = XW_DEF,
    parameter  int CW  = CW_DEF,
    parameter  int YW  = YW_DEF,
    parameter  int DEG = DEG_DEF,
    localparam int AW  = (DEG > 0) ? $clog2(DEG + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 start,
    input  logic signed [XW-1:0] x_in,
    output logic                 busy,
    output logic                 done,
    output logic signed [YW-1:0] y_out,
    output logic                 ovf
);

    state_t               r_state;
    logic signed [CW-1:0] r_coef [0:DEG];
    logic signed [YW-1:0] r_acc;
    logic signed [XW-1:0] r_x;
    logic [AW-1:0]        r_idx;
    logic signed [YW-1:0] r_y;
    logic                 r_ovf;

    logic signed [YW-1:0] w_ctop_ext;
    logic signed [YW-1:0] w_mac_y;
    logic                 w_mac_sat;

    assign w_ctop_ext = YW'(r_coef[DEG]);

    poly_mac #(
        .XW (XW),
        .CW (CW),
        .YW (YW)
    ) u_mac (
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_c   (r_coef[r_idx]),
        .o_y   (w_mac_y),
        .o_sat (w_mac_sat)
    );

    // A write in IDLE takes priority over a coincident start, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_x     <= '0;
            r_idx   <= '0;
            r_y     <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i <= DEG; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (coef_we) begin
                        if (coef_addr <= AW'(DEG)) begin
                            r_coef[coef_addr] <= coef_wdata;
                        end
                    end else if (start) begin
                        r_x   <= x_in;
                        r_acc <= w_ctop_ext;
                        r_idx <= (DEG > 0) ? AW'(DEG - 1) : '0;
                        r_ovf <= 1'b0;
                        if (DEG == 0) begin
                            r_y     <= w_ctop_ext;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    r_acc <= w_mac_y;
                    r_ovf <= r_ovf | w_mac_sat;
                    if (r_idx == '0) begin
                        r_y     <= w_mac_y;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign y_out = r_y;
    assign ovf   = r_ovf;

endmodule
